// File: rtl/uart_frame_rx_if.sv
// Bus between the UART RX byte stream, the frame decoder and the MCU-side
// command logic.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both high. The producer holds valid and its data stable until that
// edge. Input stream: in_valid/in_ready/in_data. Frame hand-off:
// frame_valid/frame_ready, with frame_cmd, frame_len and the payload read
// port held stable while frame_valid is high.
//
// The slave modport is the decoder; the master modport is its environment.
interface uart_frame_rx_if #(
   parameter int AW = 4
);
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          frame_valid;
   logic          frame_ready;
   logic [7:0]    frame_cmd;
   logic [7:0]    frame_len;
   logic [AW-1:0] pl_raddr;
   logic [7:0]    pl_rdata;
   logic          err_chk;
   logic          err_len;
   logic          err_timeout;
   logic [7:0]    err_cnt;
   logic          busy;
   logic [2:0]    dbg_state;

   modport slave (
      input  in_valid, in_data, frame_ready, pl_raddr,
      output in_ready, frame_valid, frame_cmd, frame_len, pl_rdata,
             err_chk, err_len, err_timeout, err_cnt, busy, dbg_state
   );

   modport master (
      output in_valid, in_data, frame_ready, pl_raddr,
      input  in_ready, frame_valid, frame_cmd, frame_len, pl_rdata,
             err_chk, err_len, err_timeout, err_cnt, busy, dbg_state
   );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame decoder behind the UART RX byte stream.
// Frame layout: SOF, CMD, LEN, LEN payload bytes, CHK, where
// CHK = (CMD + LEN + sum of payload) mod 256. No byte escaping.
// A verified frame is held (input back-pressured) until the consumer
// releases it; the payload is readable through a random-access port.
module uart_frame_rx #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CYC = 500_000,
   parameter int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_frame_rx_if.slave  bus
);

   // Counter only needs to reach TIMEOUT_CYC-2 before the timeout fires.
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_CMD     = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CHK     = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   state_t        state;
   logic [7:0]    cmd_r;
   logic [7:0]    len_r;
   logic [7:0]    sum;
   logic [7:0]    idx;
   logic [TW-1:0] tmo_cnt;
   logic          frame_valid_r;
   logic          err_chk_r;
   logic          err_len_r;
   logic          err_timeout_r;
   logic [7:0]    err_cnt_r;
   logic [7:0]    pl_mem [0:MAX_LEN-1];

   logic accept;
   logic tmo_hit;
   logic len_too_big;
   logic pl_last;

   assign bus.in_ready = (state != S_HOLD);
   assign accept       = bus.in_valid && bus.in_ready;

   // Fires on the idle cycle in which the counter would reach TIMEOUT_CYC-1.
   assign tmo_hit = (TIMEOUT_CYC != 0) &&
                    ((32'(tmo_cnt) + 32'd1) >= (32'(TIMEOUT_CYC) - 32'd1));

   assign len_too_big = (32'(bus.in_data) > 32'(MAX_LEN));
   assign pl_last     = (idx == (len_r - 8'd1));

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Frame decoder FSM with timeout, checksum and error accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_HUNT;
         cmd_r         <= 8'h00;
         len_r         <= 8'h00;
         sum           <= 8'h00;
         idx           <= 8'h00;
         tmo_cnt       <= '0;
         frame_valid_r <= 1'b0;
         err_chk_r     <= 1'b0;
         err_len_r     <= 1'b0;
         err_timeout_r <= 1'b0;
         err_cnt_r     <= 8'h00;
      end else begin
         err_chk_r     <= 1'b0;
         err_len_r     <= 1'b0;
         err_timeout_r <= 1'b0;
         case (state)
            S_HUNT: begin
               tmo_cnt <= '0;
               if (accept && (bus.in_data == SOF_BYTE)) begin
                  sum   <= 8'h00;
                  state <= S_CMD;
               end
            end
            S_HOLD: begin
               tmo_cnt <= '0;
               if (frame_valid_r && bus.frame_ready) begin
                  frame_valid_r <= 1'b0;
                  state         <= S_HUNT;
               end
            end
            default: begin
               // In-frame states: a byte arriving on the last allowed cycle
               // wins over the timeout.
               if (accept) begin
                  tmo_cnt <= '0;
                  case (state)
                     S_CMD: begin
                        cmd_r <= bus.in_data;
                        sum   <= sum + bus.in_data;
                        state <= S_LEN;
                     end
                     S_LEN: begin
                        if (len_too_big) begin
                           err_len_r <= 1'b1;
                           err_cnt_r <= sat_inc(err_cnt_r);
                           state     <= S_HUNT;
                        end else begin
                           len_r <= bus.in_data;
                           sum   <= sum + bus.in_data;
                           idx   <= 8'h00;
                           state <= (bus.in_data == 8'h00) ? S_CHK : S_PAYLOAD;
                        end
                     end
                     S_PAYLOAD: begin
                        sum <= sum + bus.in_data;
                        idx <= idx + 8'd1;
                        if (pl_last) state <= S_CHK;
                     end
                     S_CHK: begin
                        if (bus.in_data == sum) begin
                           frame_valid_r <= 1'b1;
                           state         <= S_HOLD;
                        end else begin
                           err_chk_r <= 1'b1;
                           err_cnt_r <= sat_inc(err_cnt_r);
                           state     <= S_HUNT;
                        end
                     end
                     default: state <= S_HUNT;
                  endcase
               end else if (tmo_hit) begin
                  err_timeout_r <= 1'b1;
                  err_cnt_r     <= sat_inc(err_cnt_r);
                  tmo_cnt       <= '0;
                  state         <= S_HUNT;
               end else if (TIMEOUT_CYC != 0) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
         endcase
      end
   end

   // Payload buffer write; contents need no reset since frame_len guards reads.
   always_ff @(posedge clk) begin
      if (accept && (state == S_PAYLOAD)) pl_mem[idx[AW-1:0]] <= bus.in_data;
   end

   assign bus.pl_rdata    = (32'(bus.pl_raddr) < 32'(len_r)) ? pl_mem[bus.pl_raddr] : 8'h00;
   assign bus.frame_valid = frame_valid_r;
   assign bus.frame_cmd   = cmd_r;
   assign bus.frame_len   = len_r;
   assign bus.err_chk     = err_chk_r;
   assign bus.err_len     = err_len_r;
   assign bus.err_timeout = err_timeout_r;
   assign bus.err_cnt     = err_cnt_r;
   assign bus.busy        = (state != S_HUNT);
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx (MAX_LEN=16, SOF=A5, TIMEOUT_CYC=20).
module tb_uart_frame_rx;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [7:0] tx_q [$];

   uart_frame_rx_if #(.AW(4)) bus ();

   uart_frame_rx #(
      .MAX_LEN     (16),
      .SOF_BYTE    (8'hA5),
      .TIMEOUT_CYC (20),
      .AW          (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one byte starting at a negedge; returns at the negedge after it was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL send_byte_wait: byte %h not accepted after %0d cycles, required < 200", b, n);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_all();
      while (tx_q.size() > 0) send_byte(tx_q.pop_front());
   endtask

   task automatic read_pl(input logic [3:0] a, input logic [7:0] exp, input string nm);
      bus.pl_raddr = a;
      #1;
      total++;
      if (bus.pl_rdata !== exp) begin
         bad++;
         $display("FAIL %s: pl_rdata[%0d] got %h expected %h", nm, a, bus.pl_rdata, exp);
      end
   endtask

   task automatic release_frame(input string nm);
      bus.frame_ready = 1'b1;
      @(negedge clk);
      bus.frame_ready = 1'b0;
      total++;
      if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: after release valid=%b in_ready=%b busy=%b expected 0/1/0",
                  nm, bus.frame_valid, bus.in_ready, bus.busy);
      end
   endtask

   task automatic check_frame(input logic [7:0] cmd, input logic [7:0] len, input string nm);
      total++;
      if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== cmd || bus.frame_len !== len ||
          bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s: valid=%b cmd=%h len=%h in_ready=%b expected 1/%h/%h/0",
                  nm, bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.in_ready, cmd, len);
      end
   endtask

   task automatic test_reset();
      total++;
      if (bus.frame_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
          bus.err_cnt !== 8'h00 || bus.frame_cmd !== 8'h00 || bus.frame_len !== 8'h00 ||
          bus.err_chk !== 1'b0 || bus.err_len !== 1'b0 || bus.err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset: valid=%b rdy=%b busy=%b cnt=%h cmd=%h len=%h errs=%b%b%b expected 0 1 0 00 00 00 000",
                  bus.frame_valid, bus.in_ready, bus.busy, bus.err_cnt, bus.frame_cmd,
                  bus.frame_len, bus.err_chk, bus.err_len, bus.err_timeout);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame();
      tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20};
      send_all();
      total++;
      if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL good_pre_chk: valid=%b busy=%b expected 0/1", bus.frame_valid, bus.busy);
      end
      send_byte(8'h33);
      check_frame(8'h01, 8'h02, "good_frame");
      read_pl(4'd0, 8'h10, "good_pl0");
      read_pl(4'd1, 8'h20, "good_pl1");
      read_pl(4'd2, 8'h00, "good_pl2");
      release_frame("good_release");
   endtask

   task automatic test_bad_chk();
      tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
      send_all();
      total++;
      if (bus.err_chk !== 1'b1 || bus.err_cnt !== 8'd1 || bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL bad_chk: err_chk=%b cnt=%h valid=%b busy=%b expected 1/01/0/0",
                  bus.err_chk, bus.err_cnt, bus.frame_valid, bus.busy);
      end
      @(negedge clk);
      total++;
      if (bus.err_chk !== 1'b0) begin
         bad++;
         $display("FAIL bad_chk_pulse: err_chk=%b expected 0 one cycle later", bus.err_chk);
      end
      tx_q = '{8'hA5, 8'h03, 8'h01, 8'h44, 8'h48};
      send_all();
      check_frame(8'h03, 8'h01, "after_bad_frame");
      read_pl(4'd0, 8'h44, "after_bad_pl0");
      release_frame("after_bad_release");
   endtask

   task automatic test_len();
      tx_q = '{8'hA5, 8'h07, 8'h11};
      send_all();
      total++;
      if (bus.err_len !== 1'b1 || bus.err_cnt !== 8'd2 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL len_err: err_len=%b cnt=%h busy=%b expected 1/02/0", bus.err_len, bus.err_cnt, bus.busy);
      end
      tx_q = '{8'hA5, 8'h07, 8'h00, 8'h07};
      send_all();
      check_frame(8'h07, 8'h00, "zero_len");
      read_pl(4'd0, 8'h00, "zero_len_pl0");
      release_frame("zero_len_release");
      // Longest legal frame: payload 00..0F, chk = 01+10+78 = 89
      tx_q = '{8'hA5, 8'h01, 8'h10};
      for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h89);
      send_all();
      check_frame(8'h01, 8'h10, "max_len");
      read_pl(4'd5, 8'h05, "max_len_pl5");
      read_pl(4'd15, 8'h0F, "max_len_pl15");
      release_frame("max_len_release");
   endtask

   task automatic test_hunt_sof();
      tx_q = '{8'h00, 8'hFF};
      send_all();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL hunt_garbage: busy=%b expected 0", bus.busy);
      end
      tx_q = '{8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h4B};
      send_all();
      check_frame(8'hA5, 8'h01, "embedded_sof");
      read_pl(4'd0, 8'hA5, "embedded_sof_pl0");
      release_frame("embedded_sof_release");
   endtask

   task automatic test_timeout();
      int k;
      tx_q = '{8'hA5, 8'h01};
      send_all();
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (bus.err_timeout) break;
      end
      total++;
      if (k !== 19 || bus.err_timeout !== 1'b1 || bus.err_cnt !== 8'd3 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL timeout: fired after %0d cycles err_timeout=%b cnt=%h busy=%b expected 19/1/03/0",
                  k, bus.err_timeout, bus.err_cnt, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
      send_all();
      check_frame(8'h01, 8'h02, "b2b_first");
      fork
         begin
            tx_q = '{8'hA5, 8'h02, 8'h01, 8'h5A, 8'h5D};
            send_all();
         end
         begin
            repeat (5) begin
               @(negedge clk);
               total++;
               if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h01) begin
                  bad++;
                  $display("FAIL b2b_hold: in_ready=%b valid=%b cmd=%h expected 0/1/01",
                           bus.in_ready, bus.frame_valid, bus.frame_cmd);
               end
            end
            bus.frame_ready = 1'b1;
            @(negedge clk);
            bus.frame_ready = 1'b0;
         end
      join
      check_frame(8'h02, 8'h01, "b2b_second");
      read_pl(4'd0, 8'h5A, "b2b_second_pl0");
      release_frame("b2b_release");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) begin
         tx_q = '{8'hA5, 8'h07, 8'h11};
         send_all();
         if (i == 9) begin
            total++;
            if (bus.err_cnt !== 8'h0D) begin
               bad++;
               $display("FAIL err_cnt_mid: got %h expected 0D", bus.err_cnt);
            end
         end
      end
      total++;
      if (bus.err_cnt !== 8'hFF || bus.err_len !== 1'b1) begin
         bad++;
         $display("FAIL err_cnt_sat: cnt=%h err_len=%b expected FF/1", bus.err_cnt, bus.err_len);
      end
   endtask

   task automatic test_async_reset();
      int pulses;
      tx_q = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
      send_all();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 || bus.err_cnt !== 8'h00 ||
          bus.in_ready !== 1'b1 || bus.frame_cmd !== 8'h00 || bus.frame_len !== 8'h00 ||
          bus.err_chk !== 1'b0 || bus.err_len !== 1'b0 || bus.err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: busy=%b valid=%b cnt=%h rdy=%b cmd=%h len=%h expected 0 0 00 1 00 00",
                  bus.busy, bus.frame_valid, bus.err_cnt, bus.in_ready, bus.frame_cmd, bus.frame_len);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.err_chk || bus.err_len || bus.err_timeout || bus.busy) pulses++;
      end
      total++;
      if (pulses !== 0 || bus.err_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_no_err: %0d cycles with err/busy, cnt=%h expected 0/00", pulses, bus.err_cnt);
      end
      tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
      send_all();
      check_frame(8'h01, 8'h02, "post_reset_frame");
      release_frame("post_reset_release");
   endtask

   // Test sequence
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = 8'h00;
      bus.frame_ready = 1'b0;
      bus.pl_raddr    = 4'd0;
      repeat (3) @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_len();
      test_hunt_sof();
      test_timeout();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Frame decoder directly downstream of the UART port's RX byte stream (rx_valid/rx_ready/rx_data).
- Hunts for a start byte, collects a length-prefixed frame into an internal payload buffer, and verifies an 8-bit additive checksum.
- Presents each good frame to the MCU-side command logic through a valid/ready handshake and a random-access payload read port.
- Back-pressures the RX FIFO while a decoded frame is waiting to be consumed.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYC, 500_000: clk cycles allowed between bytes inside a frame. 0 disables the timeout.
- AW, $clog2(MAX_LEN): payload read address width (minimum 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte available (from uart_port rx_valid)
- in_ready  out  1  decoder accepts byte (to uart_port rx_ready)
- in_data  in  8  received byte
- frame_valid  out  1  verified frame held and available
- frame_ready  in  1  consumer releases frame
- frame_cmd  out  8  command byte of held frame
- frame_len  out  8  payload length of held frame (0..MAX_LEN)
- pl_raddr  in  AW  payload read index
- pl_rdata  out  8  payload byte at pl_raddr (combinational)
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_len  out  1  one-cycle pulse: LEN > MAX_LEN
- err_timeout  out  1  one-cycle pulse: inter-byte timeout
- err_cnt  out  8  saturating count of all errors
- busy  out  1  state != HUNT

Behaviour:
- Frame format: SOF, CMD, LEN, LEN payload bytes, CHK.
- Checksum: CHK must equal (CMD + LEN + sum of payload bytes) mod 256. SOF is excluded from the sum.
- No escaping: SOF_BYTE values inside CMD, LEN, payload or CHK are treated as ordinary data.
- Byte accept: accept = in_valid && in_ready. in_ready = 1 in every state except HOLD.
- State machine (all transitions happen on accept unless noted):
  - HUNT: discard any byte != SOF_BYTE. SOF_BYTE -> CMD, clear running sum.
  - CMD: latch cmd, add to sum -> LEN.
  - LEN:
    - LEN > MAX_LEN -> pulse err_len, go to HUNT.
    - LEN == 0 -> go to CHK.
    - otherwise latch len, clear payload index, go to PAYLOAD.
  - PAYLOAD: write buf[idx], add to sum, idx++. When idx reaches len-1 on accept -> CHK.
  - CHK:
    - match -> HOLD. frame_valid rises the cycle after the CHK byte is accepted.
    - mismatch -> pulse err_chk, go to HUNT.
  - HOLD: frame_valid = 1; frame_cmd, frame_len and the buffer stay stable. On frame_valid && frame_ready -> HUNT; frame_valid = 0 the next cycle and in_ready = 1 the same next cycle.
- Timeout (TIMEOUT_CYC != 0):
  - The counter clears on every accept and on entry to CMD.
  - It increments each cycle while in CMD, LEN, PAYLOAD or CHK with no accept.
  - When it reaches TIMEOUT_CYC-1 -> pulse err_timeout, go to HUNT. An accept in that same cycle takes priority: the byte is processed and no timeout occurs.
  - The counter never runs in HUNT or HOLD.
- err_cnt: increments by 1 for each err_* pulse and saturates at 8'hFF. Error pulses are mutually exclusive.
- pl_rdata = buf[pl_raddr] when pl_raddr < frame_len, else 8'h00. Its value is only meaningful while frame_valid = 1.
- Reset values (asynchronous reset):
  - state = HUNT.
  - frame_valid, in_ready-gating state, err_*, busy, err_cnt, frame_cmd, frame_len, counters, sum = 0.
  - Buffer contents are don't-care.
- Reset mid-frame: the partial frame is dropped and no error pulse is generated.

Test Plan:
- Good frame: stream A5 01 02 10 20 33 -> frame_valid=1 one cycle after 0x33 accepted; frame_cmd=01, frame_len=02; pl_raddr 0/1/2 -> 10/20/00. Assert frame_ready -> HUNT, in_ready=1.
- Bad checksum: A5 01 02 10 20 34 -> err_chk pulse, err_cnt=1, no frame_valid. A following good frame still decodes correctly.
- Length and zero length: A5 07 11 (MAX_LEN=16) -> err_len pulse, decoder returns to HUNT. A5 07 00 07 -> frame_valid with frame_len=0.
- Hunt and embedded SOF: 00 FF A5 A5 01 A5 4B -> garbage discarded; frame_cmd=A5, frame_len=01, payload[0]=A5.
- Timeout and back-pressure: with TIMEOUT_CYC=20, send A5 01 then idle -> err_timeout 19 cycles after the last accept. A second good frame offered while the first is in HOLD -> in_ready=0 until frame_ready; no bytes lost.
- Saturation and async reset: force 260 errors -> err_cnt=FF. Assert rst_n low mid-PAYLOAD -> all outputs 0, HUNT, and no err pulse.
